priority_drain_encoder: RTL and testbench
=========================================

Name: priority_drain_encoder

Overview:
- Parametrised, sequential successor to the team's 16-to-4 priority encoder.
- Captures a WIDTH-bit request vector with a valid/ready handshake.
- Emits the index of every set bit, one per output handshake, highest-priority first, clearing each bit as it is consumed.
- Sits between event/interrupt collectors and a serial consumer (scheduler, IRQ dispatcher) that must service every asserted line, not just the winner.

Parameters:
- WIDTH, 16, request vector width; legal range 2..256.
- IDX_W, $clog2(WIDTH), index width; derived, not overridden.
- MSB_FIRST, 0, 0 = lowest set bit has priority (bit 0 first); 1 = highest set bit has priority.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_vec  input  WIDTH  request vector to drain.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block accepts in_vec this cycle.
- out_index  output  IDX_W  index of the current highest-priority pending bit.
- out_last  output  1  current beat is the final pending bit of the vector.
- out_valid  output  1  out_index/out_last are valid.
- out_ready  input  1  consumer accepts the beat.
- flush  input  1  synchronous abort; discards all pending bits.
- done  output  1  one-cycle pulse when a vector is fully drained or a zero vector is accepted.
- busy  output  1  pending bits exist (state DRAIN).

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values: pending = 0, state = IDLE, in_ready = 1, out_valid = 0, out_index = 0, out_last = 0, done = 0, busy = 0.
- Reset asserted mid-drain discards pending bits immediately, with no done pulse.
- State: pending register (WIDTH bits). FSM states are IDLE (pending == 0) and DRAIN (pending != 0).
- in_ready = (state == IDLE) OR (out_valid AND out_ready AND out_last). This allows a back-to-back reload on the final beat.
- in_ready is forced to 0 while flush = 1.
- Load: on in_valid AND in_ready, pending <= in_vec at the next edge.
  - If in_vec != 0: move to DRAIN. out_valid rises the cycle after acceptance, so latency is 1 clock.
  - If in_vec == 0: stay in IDLE, pulse done the next cycle, emit no beat.
- out_valid = busy AND NOT flush.
- out_index is the priority encode of pending:
  - MSB_FIRST = 0: lowest set bit.
  - MSB_FIRST = 1: highest set bit.
  - out_index is a function of registered state only, with no combinational path from in_vec.
- out_last = 1 when pending has exactly one bit set.
- Output hold: while out_valid AND NOT out_ready, out_index and out_last hold stable, and pending is unchanged.
- Beat: on out_valid AND out_ready, clear the bit at out_index in pending.
  - If out_last: pulse done next cycle. Go to IDLE, or reload DRAIN if a vector is accepted the same cycle.
- Simultaneous last beat and load: pending <= in_vec, and the cleared-bit result is discarded. done still pulses for the finished vector.
  - If the new in_vec == 0 in that case, done pulses once (one cycle) and the FSM goes to IDLE.
- Flush: when flush = 1, pending <= 0 and state <= IDLE at the next edge, with no done pulse.
  - Flush has priority over beat and load in the same cycle.
  - Flush in IDLE has no effect.
- Bits of in_vec set at index >= WIDTH do not exist; every beat index is < WIDTH.
- done and busy are registered outputs.

Test Plan:
- Reset then load, WIDTH=16, MSB_FIRST=0: in_vec=16'h8421, out_ready=1 → beats 0, 5, 10, 15 on consecutive cycles; out_last only with 15; done one cycle after the 15 beat.
- MSB_FIRST=1, in_vec=16'h8421 → beats 15, 10, 5, 0.
- Backpressure: in_vec=16'h0006, out_ready low for 3 cycles → out_index holds 1, out_last=0; after out_ready rises, beats 1 then 2 (last).
- Back-to-back: hold in_valid with vectors 16'h0001 then 16'h0100 → in_ready=1 on the cycle of the last beat of the first vector; the next cycle beat 8 with out_last=1; done pulses after each vector; no idle gap.
- Zero vector: in_vec=16'h0000 accepted → no out_valid; done pulses exactly once; in_ready stays 1.
- Flush and async reset:
  - in_vec=16'hFFFF drained for 2 beats, then flush → pending clears; out_valid=0 the same cycle; no done; in_ready=1 next cycle.
  - Repeat with rst pulsed mid-drain between edges → outputs go to reset values immediately.

Source files
------------

// File: rtl/priority_drain_encoder.sv
// Accepts a request vector and drains it one index per output handshake, in priority order.
// A bit is cleared from the pending set each time its index is consumed.
module priority_drain_encoder #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b0,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic             done,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             done_q, done_d;

    logic             beat_s;
    logic             load_s;
    logic [WIDTH-1:0] clear_mask_s;

    function automatic logic [IDX_W-1:0] pick_index(input logic [WIDTH-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        if (MSB_FIRST != 1'b0) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) begin
                    idx = IDX_W'(i);
                end else begin
                    idx = idx;
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    idx = IDX_W'(i);
                end else begin
                    idx = idx;
                end
            end
        end
        return idx;
    endfunction

    function automatic logic is_single(input logic [WIDTH-1:0] vec);
        return (vec != '0) && ((vec & (vec - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);
    endfunction

    // Handshake and output decode; everything downstream of pending_q only.
    always_comb begin
        busy         = (state_q == DRAIN);
        done         = done_q;
        out_index    = pick_index(pending_q);
        out_last     = is_single(pending_q);
        out_valid    = busy && !flush;
        beat_s       = out_valid && out_ready;
        in_ready     = !flush && ((state_q == IDLE) || (beat_s && out_last));
        load_s       = in_valid && in_ready;
        clear_mask_s = ~({{(WIDTH-1){1'b0}}, 1'b1} << out_index);
    end

    // Next-state: flush wins, then a load overrides the cleared result of a final beat.
    always_comb begin
        pending_d = pending_q;
        state_d   = state_q;
        done_d    = 1'b0;
        if (flush) begin
            pending_d = '0;
            state_d   = IDLE;
        end else begin
            if (beat_s) begin
                pending_d = pending_q & clear_mask_s;
                if (out_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end else begin
                pending_d = pending_q;
            end
            if (load_s) begin
                pending_d = in_vec;
                if (in_vec != '0) begin
                    state_d = DRAIN;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                pending_d = pending_d;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            state_q   <= IDLE;
            done_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            state_q   <= state_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_priority_drain_encoder.sv
// Directed bench for priority_drain_encoder: both priority orders, backpressure,
// back-to-back reload, zero vector, flush and asynchronous reset, with a beat scoreboard.
module tb_priority_drain_encoder;

    typedef struct packed {
        logic [3:0] idx;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_vec0, in_vec1;
    logic        in_valid0, in_valid1;
    logic        in_ready0, in_ready1;
    logic [3:0]  out_index0, out_index1;
    logic        out_last0, out_last1;
    logic        out_valid0, out_valid1;
    logic        out_ready0, out_ready1;
    logic        flush0, flush1;
    logic        done0, done1;
    logic        busy0, busy1;

    beat_t q0[$];
    beat_t q1[$];
    int    n_vec  = 0;
    int    n_miss = 0;

    always #5 clk = ~clk;

    priority_drain_encoder #(.WIDTH(16), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_vec(in_vec0), .in_valid(in_valid0), .in_ready(in_ready0),
        .out_index(out_index0), .out_last(out_last0), .out_valid(out_valid0),
        .out_ready(out_ready0), .flush(flush0), .done(done0), .busy(busy0)
    );

    priority_drain_encoder #(.WIDTH(16), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_vec(in_vec1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_index(out_index1), .out_last(out_last1), .out_valid(out_valid1),
        .out_ready(out_ready1), .flush(flush1), .done(done1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected beat order for a vector.
    task automatic push_vec(input logic [15:0] v, input int which, input bit msb);
        int    n;
        int    cnt;
        int    i;
        beat_t b;
        n   = $countones(v);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            i = msb ? 15 - k : k;
            if (v[i]) begin
                cnt++;
                b.idx  = 4'(i);
                b.last = (cnt == n);
                if (which == 0) q0.push_back(b);
                else q1.push_back(b);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle: check valid, pop/compare any handshaked beat, then advance.
    task automatic obs(input logic ev0, input logic ev1);
        beat_t e;
        #1;
        chk("out_valid0", out_valid0, ev0);
        chk("out_valid1", out_valid1, ev1);
        if (out_valid0 && out_ready0) begin
            if (q0.size() == 0) begin
                chk("q0_unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("idx0", out_index0, e.idx);
                chk("last0", out_last0, e.last);
            end
        end
        if (out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                chk("q1_unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("idx1", out_index1, e.idx);
                chk("last1", out_last1, e.last);
            end
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        in_vec0 = 16'h0000; in_valid0 = 1'b0; out_ready0 = 1'b0; flush0 = 1'b0;
        in_vec1 = 16'h0000; in_valid1 = 1'b0; out_ready1 = 1'b0; flush1 = 1'b0;
        #2;
        chk("rst_in_ready", in_ready0, 1'b1);
        chk("rst_out_valid", out_valid0, 1'b0);
        chk("rst_out_index", out_index0, 4'd0);
        chk("rst_out_last", out_last0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        #10;
        rst = 1'b0;
        tick();

        // LSB-first drain of 8421
        in_vec0 = 16'h8421; in_valid0 = 1'b1; out_ready0 = 1'b1;
        #1;
        chk("t1_in_ready", in_ready0, 1'b1);
        tick();
        in_valid0 = 1'b0;
        push_vec(16'h8421, 0, 1'b0);
        chk("t1_busy", busy0, 1'b1);
        chk("t1_done_early", done0, 1'b0);
        for (int k = 0; k < 4; k++) obs(1'b1, 1'b0);
        chk("t1_done", done0, 1'b1);
        chk("t1_busy_end", busy0, 1'b0);
        tick();
        chk("t1_done_once", done0, 1'b0);

        // MSB-first drain of 8421
        in_vec1 = 16'h8421; in_valid1 = 1'b1; out_ready1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        push_vec(16'h8421, 1, 1'b1);
        for (int k = 0; k < 4; k++) obs(1'b0, 1'b1);
        chk("t2_done", done1, 1'b1);
        out_ready1 = 1'b0;

        // Backpressure
        in_vec0 = 16'h0006; in_valid0 = 1'b1; out_ready0 = 1'b0;
        tick();
        in_valid0 = 1'b0;
        push_vec(16'h0006, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("t3_hold_idx", out_index0, 4'd1);
            chk("t3_hold_last", out_last0, 1'b0);
            chk("t3_hold_ready", in_ready0, 1'b0);
            obs(1'b1, 1'b0);
        end
        out_ready0 = 1'b1;
        obs(1'b1, 1'b0);
        obs(1'b1, 1'b0);
        chk("t3_done", done0, 1'b1);

        // Back-to-back reload on the final beat
        in_vec0 = 16'h0001; in_valid0 = 1'b1;
        tick();
        push_vec(16'h0001, 0, 1'b0);
        in_vec0 = 16'h0100;
        #1;
        chk("t4_in_ready_last", in_ready0, 1'b1);
        obs(1'b1, 1'b0);
        push_vec(16'h0100, 0, 1'b0);
        in_valid0 = 1'b0;
        chk("t4_done_a", done0, 1'b1);
        chk("t4_busy_a", busy0, 1'b1);
        obs(1'b1, 1'b0);
        chk("t4_done_b", done0, 1'b1);
        chk("t4_busy_b", busy0, 1'b0);
        tick();

        // Zero vector
        in_vec0 = 16'h0000; in_valid0 = 1'b1;
        #1;
        chk("t5_in_ready", in_ready0, 1'b1);
        tick();
        in_valid0 = 1'b0;
        chk("t5_done", done0, 1'b1);
        chk("t5_no_valid", out_valid0, 1'b0);
        chk("t5_busy", busy0, 1'b0);
        chk("t5_in_ready_after", in_ready0, 1'b1);
        tick();
        chk("t5_done_once", done0, 1'b0);

        // Flush mid-drain
        in_vec0 = 16'hFFFF; in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        push_vec(16'hFFFF, 0, 1'b0);
        obs(1'b1, 1'b0);
        obs(1'b1, 1'b0);
        flush0 = 1'b1;
        #1;
        chk("t6_flush_valid", out_valid0, 1'b0);
        chk("t6_flush_ready", in_ready0, 1'b0);
        tick();
        flush0 = 1'b0;
        q0.delete();
        #1;
        chk("t6_busy", busy0, 1'b0);
        chk("t6_no_done", done0, 1'b0);
        chk("t6_in_ready", in_ready0, 1'b1);
        chk("t6_out_valid", out_valid0, 1'b0);
        tick();
        chk("t6_no_done2", done0, 1'b0);

        // Asynchronous reset mid-drain
        in_vec0 = 16'hFFFF; in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        push_vec(16'hFFFF, 0, 1'b0);
        obs(1'b1, 1'b0);
        obs(1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_busy", busy0, 1'b0);
        chk("t7_out_valid", out_valid0, 1'b0);
        chk("t7_in_ready", in_ready0, 1'b1);
        chk("t7_out_index", out_index0, 4'd0);
        chk("t7_out_last", out_last0, 1'b0);
        chk("t7_done", done0, 1'b0);
        q0.delete();
        #1;
        rst = 1'b0;
        tick();
        chk("t7_no_done", done0, 1'b0);
        chk("t7_idle_valid", out_valid0, 1'b0);

        chk("q0_empty", q0.size(), 32'd0);
        chk("q1_empty", q1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
